div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; the only supported value is 32.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  divide instruction present in EX; sampled only in IDLE.
REQ-005 Port: is_signed  input  1  1 = DIV, 0 = DIVU; sampled with start.
REQ-006 Port: dividend  input  WIDTH  numerator; sampled with start.
REQ-007 Port: divisor  input  WIDTH  denominator; sampled with start.
REQ-008 Port: stall_EX  output  1  holds fetch/EX while a divide is in flight.
REQ-009 Port: lo  output  WIDTH  quotient register.
REQ-010 Port: hi  output  WIDTH  remainder register.
REQ-011 Port: done  output  1  one-cycle pulse; lo/hi are valid in this cycle.
REQ-012 Port: div_by_zero  output  1  qualifies done; high when the divisor was 0.

Function
REQ-013 States SHALL be IDLE, RUN, FIX and DONE, held in a registered state machine.
REQ-014 In IDLE with start=1 the block SHALL latch the operands and is_signed, clear the 6-bit iteration counter, and go to RUN, or to DONE if divisor==0.
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle on operand magnitudes, going to FIX after exactly WIDTH steps (counter 0..31).
REQ-016 FIX SHALL apply signs: quotient negated if sign(dividend) XOR sign(divisor); remainder takes the sign of dividend; it then goes to DONE.
REQ-017 On entering DONE, lo/hi SHALL be updated; in DONE, done=1 for one cycle; the next state SHALL be IDLE unconditionally.
REQ-018 Latency: with start accepted in cycle 0, done SHALL be high in cycle WIDTH+2 (34); with divide-by-zero, in cycle 1.
REQ-019 stall_EX SHALL equal (IDLE and start) or RUN or FIX; it SHALL be low in DONE so the instruction retires.
REQ-020 start SHALL be ignored in RUN, FIX and DONE; in-flight operands SHALL NOT change.
REQ-021 Divide by zero: lo=0xFFFFFFFF, hi=dividend, div_by_zero=1 together with done.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, with no error flag.
REQ-023 lo/hi SHALL hold their values between completions.
REQ-024 div_by_zero SHALL be 0 whenever done=0.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, counter=0, lo=0, hi=0, done=0, div_by_zero=0 and stall_EX=0 (given start=0).
REQ-026 Reset during RUN/FIX SHALL abort the operation; after release, no done pulse SHALL appear for it.

Configuration
REQ-027 Macro DIV_SIGNED_EN defined: is_signed SHALL be honoured and FIX SHALL perform sign correction.
REQ-028 DIV_SIGNED_EN undefined: is_signed SHALL be ignored, all divides SHALL be unsigned, FIX SHALL pass results unchanged, and latency SHALL be unchanged.

Verification
REQ-029 DIVU 100/7, start at cycle 0 -> stall_EX high cycles 0-33, done at cycle 34, lo=14, hi=2, div_by_zero=0.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 with DIV_SIGNED_EN -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; same stimulus without the macro -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-031 DIVU 0x1234 / 0, start at cycle 0 -> done and div_by_zero at cycle 1, lo=0xFFFFFFFF, hi=0x00001234, stall_EX high only in cycle 0.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0 at cycle 34.
REQ-033 Change start/operands to 9/3 during cycles 5-20 of a 100/7 divide -> the result is still lo=14, hi=2 at cycle 34, with no second done.
REQ-034 rst low at cycle 10 of a divide -> stall_EX=0, lo=hi=0 immediately, and no done for the next 40 cycles without start.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl -- multi-cycle integer divide controller (DIV / DIVU).
//
// Restoring shift-subtract divider on operand magnitudes, one quotient bit
// per cycle, followed by a sign-fix cycle. Holds the pipeline via stall_EX
// while a divide is in flight and pulses done when lo/hi are valid.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active low
//   start        divide instruction present in EX (sampled only in IDLE)
//   is_signed    1 = DIV, 0 = DIVU (sampled with start)
//   dividend     numerator   (sampled with start)
//   divisor      denominator (sampled with start)
//   stall_EX     hold fetch/EX while the divide is in flight
//   lo           quotient register
//   hi           remainder register
//   done         one-cycle pulse, lo/hi valid
//   div_by_zero  qualifies done, divisor was zero
//
// Build option
//   DIV_SIGNED_EN  defined: is_signed honoured, FIX applies sign correction.
//                  undefined: every divide is unsigned, FIX passes through.
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; latches operands on start
// RUN   | one restoring step per cycle, WIDTH steps (counter 0..WIDTH-1)
// FIX   | sign correction of quotient/remainder, loads lo/hi
// DONE  | done pulse for one cycle, then back to IDLE

module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall_EX,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic             signed_op;

`ifdef DIV_SIGNED_EN
    assign signed_op = is_signed;
`else
    logic unused_is_signed;
    assign signed_op        = 1'b0;
    assign unused_is_signed = is_signed;
`endif

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

    assign dvd_neg = signed_op & dividend[WIDTH-1];
    assign dvs_neg = signed_op & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

    // Partial remainder stays below the divisor, so the shifted value fits in
    // WIDTH+1 bits and the top bit of the difference is the borrow.
    logic [WIDTH:0] rem_sh, diff;

    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dbz_d   = dbz_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (divisor == '0) begin
                        lo_d    = '1;
                        hi_d    = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        quo_d   = dvd_mag;
                        rem_d   = '0;
                        dvs_d   = dvs_mag;
                        negq_d  = dvd_neg ^ dvs_neg;
                        negr_d  = dvd_neg;
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = negq_q ? (~quo_q + 1'b1) : quo_q;
                hi_d    = negr_q ? (~rem_q + 1'b1) : rem_q;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dbz_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dbz_q   <= dbz_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign done        = (state_q == S_DONE);
    assign div_by_zero = done & dbz_q;
    assign stall_EX    = ((state_q == S_IDLE) & start) | (state_q == S_RUN) | (state_q == S_FIX);
    assign lo          = lo_q;
    assign hi          = hi_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        stall_EX;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        done;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    int          obs_done_cyc;
    int          obs_done_cnt;
    int          obs_stall_bad;
    int          obs_dbz_bad;
    logic [31:0] obs_lo;
    logic [31:0] obs_hi;
    logic        obs_dbz;

    div_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .stall_EX    (stall_EX),
        .lo          (lo),
        .hi          (hi),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Launches a divide in cycle 0 and observes ncyc following cycles.
    // stall_last is the last cycle in which stall_EX must be high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int stall_last, input int ncyc, input bit disturb);
        obs_done_cyc  = -1;
        obs_done_cnt  = 0;
        obs_stall_bad = 0;
        obs_dbz_bad   = 0;
        obs_lo        = 'x;
        obs_hi        = 'x;
        obs_dbz       = 1'bx;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        #1;
        if (stall_EX !== 1'b1) obs_stall_bad++;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) start = 1'b0;
            if (disturb && cyc >= 5 && cyc <= 20) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else if (disturb && cyc == 21) begin
                start = 1'b0;
            end
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                if (obs_done_cnt == 0) begin
                    obs_done_cyc = cyc;
                    obs_lo       = lo;
                    obs_hi       = hi;
                    obs_dbz      = div_by_zero;
                end
                obs_done_cnt++;
            end
            if (div_by_zero === 1'b1 && done !== 1'b1) obs_dbz_bad++;
            if (stall_EX !== logic'(cyc <= stall_last)) obs_stall_bad++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({stall_EX, done, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got stall/done/dbz=%b expected 000", {stall_EX, done, div_by_zero});
        end
        checks++;
        if (lo !== 32'h0 || hi !== 32'h0) begin
            errors++;
            $display("FAIL reset_lohi: got lo=%h hi=%h expected 0/0", lo, hi);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_divu;
        run_op(32'd100, 32'd7, 1'b0, 33, 40, 1'b0);
        checks++;
        if (obs_done_cyc !== 34 || obs_done_cnt !== 1) begin
            errors++;
            $display("FAIL divu_latency: got cycle=%0d count=%0d expected 34/1", obs_done_cyc, obs_done_cnt);
        end
        checks++;
        if (obs_lo !== 32'd14 || obs_hi !== 32'd2 || obs_dbz !== 1'b0) begin
            errors++;
            $display("FAIL divu_result: got lo=%h hi=%h dbz=%b expected e/2/0", obs_lo, obs_hi, obs_dbz);
        end
        checks++;
        if (obs_stall_bad !== 0 || obs_dbz_bad !== 0) begin
            errors++;
            $display("FAIL divu_stall: got stall_bad=%0d dbz_bad=%0d expected 0/0", obs_stall_bad, obs_dbz_bad);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL divu_hold: got lo=%h hi=%h expected e/2", lo, hi);
        end

        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 33, 36, 1'b0);
        checks++;
        if (obs_done_cyc !== 34 || obs_lo !== 32'hFFFFFFFF || obs_hi !== 32'h0) begin
            errors++;
            $display("FAIL divu_max: got cycle=%0d lo=%h hi=%h expected 34/ffffffff/0", obs_done_cyc, obs_lo, obs_hi);
        end

        run_op(32'd5, 32'd10, 1'b0, 33, 36, 1'b0);
        checks++;
        if (obs_lo !== 32'd0 || obs_hi !== 32'd5) begin
            errors++;
            $display("FAIL divu_small: got lo=%h hi=%h expected 0/5", obs_lo, obs_hi);
        end

        run_op(32'hFFFFFFF9, 32'd2, 1'b0, 33, 36, 1'b0);
        checks++;
        if (obs_lo !== 32'h7FFFFFFC || obs_hi !== 32'h1) begin
            errors++;
            $display("FAIL divu_large: got lo=%h hi=%h expected 7ffffffc/1", obs_lo, obs_hi);
        end
    endtask

    task automatic test_signed;
        logic [31:0] exp_lo, exp_hi;
`ifdef DIV_SIGNED_EN
        exp_lo = 32'hFFFFFFFD;
        exp_hi = 32'hFFFFFFFF;
`else
        exp_lo = 32'h7FFFFFFC;
        exp_hi = 32'h00000001;
`endif
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 33, 36, 1'b0);
        checks++;
        if (obs_done_cyc !== 34 || obs_lo !== exp_lo || obs_hi !== exp_hi) begin
            errors++;
            $display("FAIL div_neg7_2: got cycle=%0d lo=%h hi=%h expected 34/%h/%h",
                     obs_done_cyc, obs_lo, obs_hi, exp_lo, exp_hi);
        end
`ifdef DIV_SIGNED_EN
        exp_lo = 32'hFFFFFFFD;
        exp_hi = 32'h00000001;
`else
        exp_lo = 32'h00000000;
        exp_hi = 32'h00000007;
`endif
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, 33, 36, 1'b0);
        checks++;
        if (obs_lo !== exp_lo || obs_hi !== exp_hi) begin
            errors++;
            $display("FAIL div_7_neg2: got lo=%h hi=%h expected %h/%h", obs_lo, obs_hi, exp_lo, exp_hi);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] exp_lo, exp_hi;
`ifdef DIV_SIGNED_EN
        exp_lo = 32'h80000000;
        exp_hi = 32'h00000000;
`else
        exp_lo = 32'h00000000;
        exp_hi = 32'h80000000;
`endif
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 33, 36, 1'b0);
        checks++;
        if (obs_done_cyc !== 34 || obs_lo !== exp_lo || obs_hi !== exp_hi || obs_dbz !== 1'b0) begin
            errors++;
            $display("FAIL div_overflow: got cycle=%0d lo=%h hi=%h dbz=%b expected 34/%h/%h/0",
                     obs_done_cyc, obs_lo, obs_hi, obs_dbz, exp_lo, exp_hi);
        end
    endtask

    task automatic test_div_zero;
        run_op(32'h1234, 32'h0, 1'b0, 0, 6, 1'b0);
        checks++;
        if (obs_done_cyc !== 1 || obs_done_cnt !== 1 || obs_dbz !== 1'b1) begin
            errors++;
            $display("FAIL dbz_timing: got cycle=%0d count=%0d dbz=%b expected 1/1/1",
                     obs_done_cyc, obs_done_cnt, obs_dbz);
        end
        checks++;
        if (obs_lo !== 32'hFFFFFFFF || obs_hi !== 32'h00001234) begin
            errors++;
            $display("FAIL dbz_result: got lo=%h hi=%h expected ffffffff/00001234", obs_lo, obs_hi);
        end
        checks++;
        if (obs_stall_bad !== 0 || obs_dbz_bad !== 0) begin
            errors++;
            $display("FAIL dbz_stall: got stall_bad=%0d dbz_bad=%0d expected 0/0", obs_stall_bad, obs_dbz_bad);
        end
    endtask

    task automatic test_ignore_start;
        run_op(32'd100, 32'd7, 1'b0, 33, 50, 1'b1);
        checks++;
        if (obs_done_cyc !== 34 || obs_done_cnt !== 1) begin
            errors++;
            $display("FAIL ignore_latency: got cycle=%0d count=%0d expected 34/1", obs_done_cyc, obs_done_cnt);
        end
        checks++;
        if (obs_lo !== 32'd14 || obs_hi !== 32'd2) begin
            errors++;
            $display("FAIL ignore_result: got lo=%h hi=%h expected e/2", obs_lo, obs_hi);
        end
        dividend = '0;
        divisor  = '0;
    endtask

    task automatic test_reset_abort;
        int n_done;
        n_done = 0;
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (stall_EX !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_ctrl: got stall=%b done=%b dbz=%b expected 0/0/0", stall_EX, done, div_by_zero);
        end
        checks++;
        if (lo !== 32'h0 || hi !== 32'h0) begin
            errors++;
            $display("FAIL abort_lohi: got lo=%h hi=%h expected 0/0", lo, hi);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1 || stall_EX === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL abort_nodone: got %0d active cycles expected 0", n_done);
        end
    endtask

    initial begin
        test_reset;
        test_divu;
        test_signed;
        test_overflow;
        test_div_zero;
        test_ignore_start;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
